ftdi_tx_arbiter: RTL
====================

// Module: ftdi_tx_arbiter
// PURPOSE
//  Packet-level round-robin arbiter sharing the single USB TX stream of the 245fifo FSM between
//  NUM_REQ requesters (e.g. sample readback, status/ack packets). A grant is held from first beat
//  to tlast, so packets never interleave on USB. Stalled owners are released by a watchdog.
//  Sits between the requester stream sources and the FSM's tx_tvalid/tx_tready/tx_tdata/tx_tkeep.
// PARAMETERS
//  CHIP_EW       0   FTDI data width code: data W=8<<CHIP_EW, keep K=1<<CHIP_EW (matches FSM)
//  NUM_REQ       2   number of requesters, 2..8
//  IDLE_TIMEOUT  1024 cycles an owner may hold grant with s_tvalid low; 0 disables watchdog
// PORTS
//  clk            in   1          system clock
//  rstn           in   1          async active-low reset
//  s_tvalid       in   NUM_REQ    per-requester beat valid
//  s_tready       out  NUM_REQ    per-requester beat accept
//  s_tdata        in   NUM_REQ*W  requester i data at [i*W +: W]
//  s_tkeep        in   NUM_REQ*K  requester i byte enables at [i*K +: K]
//  s_tlast        in   NUM_REQ    last beat of requester packet
//  m_tvalid       out  1          to FSM tx_tvalid
//  m_tready       in   1          from FSM tx_tready
//  m_tdata        out  W          to FSM tx_tdata
//  m_tkeep        out  K          to FSM tx_tkeep
//  grant_id       out  3          current/last owner index
//  busy           out  1          1 while in S_GRANT
//  timeout_err    out  NUM_REQ    sticky: requester i was released by watchdog
//  err_clear      in   1          synchronous clear of timeout_err
//  pkt_cnt        out  16         packets completed via tlast, wraps at 65535->0
// BEHAVIOUR
//  Reset: state=S_IDLE, rr_ptr=0, grant_id=0, wdog=0, timeout_err=0, pkt_cnt=0; all s_tready,
//   m_tvalid, busy = 0; m_tdata/m_tkeep = 0.
//  S_IDLE: m_tvalid=0, s_tready=0. If any s_tvalid: grant first i scanning rr_ptr, rr_ptr+1, ...
//   mod NUM_REQ; register grant_id, wdog<=0, go S_GRANT. Arbitration latency 1 cycle; no beat moves
//   in S_IDLE.
//  S_GRANT (owner g=grant_id): combinational mux, no added latency: m_tvalid=s_tvalid[g],
//   m_tdata/m_tkeep=slice g, s_tready[g]=m_tready, s_tready[others]=0; m_tdata/m_tkeep=0 in S_IDLE.
//  Beat = m_tvalid & m_tready. Beat with s_tlast[g]: pkt_cnt++, rr_ptr<=(g+1)%NUM_REQ, go S_IDLE.
//  Watchdog: wdog<=0 on any beat or when s_tvalid[g]=1 & m_tready=0 (USB backpressure is not an
//   owner fault); increments when s_tvalid[g]=0. On the cycle wdog==IDLE_TIMEOUT-1 with
//   s_tvalid[g]=0: set timeout_err[g], rr_ptr<=(g+1)%NUM_REQ, go S_IDLE; packet is truncated, no
//   tlast emitted, pkt_cnt unchanged. IDLE_TIMEOUT=0: counter held at 0, never fires.
//  Simultaneous: tlast beat on the watchdog-fire cycle -> tlast wins (normal completion, no error).
//   err_clear in the same cycle as a new set -> set wins.
//  Single pending requester re-granted after own packet (1 idle cycle between packets).
//  Partial tkeep beats pass through unchanged; FSM handles them. Inputs to non-owners ignored.
//  rstn low mid-packet: immediate return to reset values; downstream sees m_tvalid drop async.
//  State encoding free; unreachable states recover to S_IDLE.
// TESTING
//  1 Reset: hold rstn=0, drive all s_tvalid=1 -> all outputs 0; release -> grant_id=0 after 1 cycle.
//  2 RR: req0 and req1 each stream 3-beat packets, m_tready=1 -> order 0,1,0,1; pkt_cnt=4;
//    no interleave; 1 idle cycle between packets.
//  3 Backpressure: req1 4-beat packet, m_tready toggles 1,0 for 2000 cycles, IDLE_TIMEOUT=1024 ->
//    full packet delivered, timeout_err=0.
//  4 Watchdog: req0 sends 2 beats then s_tvalid=0 -> after 1024 low cycles busy=0,
//    timeout_err[0]=1, waiting req1 granted next cycle; err_clear=1 -> timeout_err=0.
//  5 Boundary: NUM_REQ=3, rr_ptr=2, only req2 valid -> granted; tlast on watchdog-fire cycle ->
//    no error; pkt_cnt preset near 65535 wraps to 0.
//  6 Mid-packet reset: assert rstn=0 on beat 2 of 5 -> outputs 0 async; after release next grant
//    scans from requester 0.

Source files
------------

// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one USB TX stream between NUM_REQ sources.
// A grant is held from the first beat to tlast; a watchdog releases owners that stop sending.
module ftdi_tx_arbiter #(
  parameter int CHIP_EW      = 0,
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                s_tvalid,
  output logic [NUM_REQ-1:0]                s_tready,
  input  logic [NUM_REQ*(8<<CHIP_EW)-1:0]   s_tdata,
  input  logic [NUM_REQ*(1<<CHIP_EW)-1:0]   s_tkeep,
  input  logic [NUM_REQ-1:0]                s_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [(8<<CHIP_EW)-1:0]           m_tdata,
  output logic [(1<<CHIP_EW)-1:0]           m_tkeep,
  output logic [2:0]                        grant_id,
  output logic                              busy,
  output logic [NUM_REQ-1:0]                timeout_err,
  input  logic                              err_clear,
  output logic [15:0]                       pkt_cnt
);

  localparam int W   = 8 << CHIP_EW;
  localparam int K   = 1 << CHIP_EW;
  localparam int WDW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_rr_ptr;
  logic [2:0]         r_grant_id;
  logic               r_busy;
  logic [WDW-1:0]     r_wdog;
  logic [NUM_REQ-1:0] r_timeout_err;
  logic [15:0]        r_pkt_cnt;

  logic               w_in_grant;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [W-1:0]       w_sel_data;
  logic [K-1:0]       w_sel_keep;
  logic               w_arb_found;
  logic [2:0]         w_arb_id;
  logic [3:0]         w_sum;
  logic               w_beat;
  logic               w_done;
  logic               w_fire;
  logic [2:0]         w_g_next;

  assign w_in_grant = (r_state == S_GRANT);
  assign w_gnt_oh   = NUM_REQ'(1'b1) << r_grant_id;
  // Requests rotated so that bit 0 is the requester at rr_ptr.
  assign w_rot      = NUM_REQ'({s_tvalid, s_tvalid} >> r_rr_ptr);
  assign w_g_next   = (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : (r_grant_id + 3'd1);

  // AND-OR mux of the owner's stream signals.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_sel_keep  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_valid = w_sel_valid | (s_tvalid[i] & w_gnt_oh[i]);
      w_sel_last  = w_sel_last  | (s_tlast[i]  & w_gnt_oh[i]);
      w_sel_data  = w_sel_data  | (s_tdata[i*W +: W] & {W{w_gnt_oh[i]}});
      w_sel_keep  = w_sel_keep  | (s_tkeep[i*K +: K] & {K{w_gnt_oh[i]}});
    end
  end

  // Round-robin search: descending scan so the lowest rotated offset wins.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_id    = 3'd0;
    w_sum       = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      w_sum = (w_sum >= 4'(NUM_REQ)) ? (w_sum - 4'(NUM_REQ)) : w_sum;
      if (w_rot[k]) begin
        w_arb_found = 1'b1;
        w_arb_id    = w_sum[2:0];
      end else begin
        w_arb_found = w_arb_found;
        w_arb_id    = w_arb_id;
      end
    end
  end

  assign m_tvalid = w_in_grant & w_sel_valid;
  assign m_tdata  = w_in_grant ? w_sel_data : '0;
  assign m_tkeep  = w_in_grant ? w_sel_keep : '0;
  assign s_tready = w_in_grant ? (w_gnt_oh & {NUM_REQ{m_tready}}) : '0;

  assign w_beat = m_tvalid & m_tready;
  assign w_done = w_beat & w_sel_last;
  // Firing requires the owner idle, so a tlast beat on the same cycle always completes normally.
  assign w_fire = (IDLE_TIMEOUT != 0) && w_in_grant && !w_sel_valid && (r_wdog == WDOG_LAST);

  // Next-state logic.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_arb_found) begin
          w_state_nxt = S_GRANT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_done || w_fire) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_GRANT);
    end
  end

  // Grant owner, round-robin pointer, packet counter and sticky timeout flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant_id    <= 3'd0;
      r_rr_ptr      <= 3'd0;
      r_pkt_cnt     <= 16'd0;
      r_timeout_err <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_arb_found) begin
        r_grant_id <= w_arb_id;
      end
      if (w_done || w_fire) begin
        r_rr_ptr <= w_g_next;
      end
      if (w_done) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      r_timeout_err <= (err_clear ? '0 : r_timeout_err) | (w_fire ? w_gnt_oh : '0);
    end
  end

  // Watchdog counts only owner-idle cycles; USB backpressure with valid high is not a fault.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog <= '0;
    end else if ((IDLE_TIMEOUT == 0) || !w_in_grant || w_sel_valid || w_fire) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDW'(1);
    end
  end

  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign pkt_cnt     = r_pkt_cnt;

endmodule
